decode_stage: RTL

Instruction decode stage for the RISC-V core. It takes a fetched 32-bit RV32I instruction and its PC and decodes them into the 5-bit ALU operation code, operand selects, register addresses, the sign-extended immediate and memory/writeback controls. Results are held in a registered ID/EX pipeline stage with stall and flush control. Its outputs feed the execute-stage ALU (ALU_IN1/ALU_IN2/ALU_INSTRUCTION) and the downstream memory/writeback stages.

---
 rtl/decode_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode feeding a registered ID/EX stage.
//
// Purpose: turns a fetched instruction word and its PC into the ALU operation
// code, operand selects, register indices, a sign-extended immediate and the
// memory/writeback enables. The decode is purely combinational into a single
// stage register, so every output comes straight from a flop, one cycle after
// the inputs were presented.
//
// Ports:
//   CLK, RST             rising-edge clock, synchronous active-high reset
//   INSTRUCTION_IN       fetched instruction word
//   PC_IN                PC of INSTRUCTION_IN
//   VALID_IN             instruction/PC inputs are valid this cycle
//   STALL                hold the stage register
//   FLUSH                replace the stage contents with a bubble
//   VALID_OUT            stage holds a valid instruction (including illegal ones)
//   PC_OUT               registered PC
//   ALU_INSTRUCTION      ALU operation code
//   ALU_IN1_SEL          0 = rs1, 1 = PC, 2 = zero
//   ALU_IN2_SEL          0 = rs2, 1 = immediate
//   RS1_ADDR/RS2_ADDR/RD_ADDR  register indices (0 when the format has none)
//   IMMEDIATE            sign-extended immediate (zero-extended shamt for shifts)
//   REG_WRITE/MEM_READ/MEM_WRITE  side-effect enables
//   MEM_FUNCT3           load/store size/sign field
//   ILLEGAL_INSTRUCTION  the registered instruction did not decode
//
// Register update priority per edge: RST > FLUSH > STALL > load.

module decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INSTRUCTION_IN,
  input  logic [DATA_WIDTH-1:0] PC_IN,
  input  logic                  VALID_IN,
  input  logic                  STALL,
  input  logic                  FLUSH,
  output logic                  VALID_OUT,
  output logic [DATA_WIDTH-1:0] PC_OUT,
  output logic [4:0]            ALU_INSTRUCTION,
  output logic [1:0]            ALU_IN1_SEL,
  output logic                  ALU_IN2_SEL,
  output logic [4:0]            RS1_ADDR,
  output logic [4:0]            RS2_ADDR,
  output logic [4:0]            RD_ADDR,
  output logic [DATA_WIDTH-1:0] IMMEDIATE,
  output logic                  REG_WRITE,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [2:0]            MEM_FUNCT3,
  output logic                  ILLEGAL_INSTRUCTION
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // ALU operation codes seen by the execute stage
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;
  localparam logic [4:0] ALU_SLLI = 5'd11;
  localparam logic [4:0] ALU_SRLI = 5'd12;
  localparam logic [4:0] ALU_SRAI = 5'd13;
  localparam logic [4:0] ALU_JAL  = 5'd14;
  localparam logic [4:0] ALU_JALR = 5'd15;
  localparam logic [4:0] ALU_BEQ  = 5'd16;
  localparam logic [4:0] ALU_BNE  = 5'd17;
  localparam logic [4:0] ALU_BLT  = 5'd18;
  localparam logic [4:0] ALU_BGE  = 5'd19;
  localparam logic [4:0] ALU_BLTU = 5'd20;
  localparam logic [4:0] ALU_BGEU = 5'd21;

  // Operand selects
  localparam logic [1:0] IN1_RS1  = 2'd0;
  localparam logic [1:0] IN1_PC   = 2'd1;
  localparam logic [1:0] IN1_ZERO = 2'd2;
  localparam logic       IN2_RS2  = 1'b0;
  localparam logic       IN2_IMM  = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic [4:0]            alu;
    logic [1:0]            in1_sel;
    logic                  in2_sel;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] pc;
  } stage_t;

  stage_t stage_q;
  stage_t dec;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [2:0] funct3;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [6:0] funct7;

  assign opcode = INSTRUCTION_IN[6:0];
  assign rd_f   = INSTRUCTION_IN[11:7];
  assign funct3 = INSTRUCTION_IN[14:12];
  assign rs1_f  = INSTRUCTION_IN[19:15];
  assign rs2_f  = INSTRUCTION_IN[24:20];
  assign funct7 = INSTRUCTION_IN[31:25];

  // Immediate formats, all sign-extended from instruction bit 31
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] imm_j;
  logic [DATA_WIDTH-1:0] imm_shamt;

  assign imm_i = {{(DATA_WIDTH-11){INSTRUCTION_IN[31]}}, INSTRUCTION_IN[30:20]};
  assign imm_s = {{(DATA_WIDTH-11){INSTRUCTION_IN[31]}}, INSTRUCTION_IN[30:25],
                  INSTRUCTION_IN[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){INSTRUCTION_IN[31]}}, INSTRUCTION_IN[7],
                  INSTRUCTION_IN[30:25], INSTRUCTION_IN[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-31){INSTRUCTION_IN[31]}}, INSTRUCTION_IN[30:12],
                  12'b0};
  assign imm_j = {{(DATA_WIDTH-20){INSTRUCTION_IN[31]}}, INSTRUCTION_IN[19:12],
                  INSTRUCTION_IN[20], INSTRUCTION_IN[30:21], 1'b0};
  // Shift amounts are unsigned, so bit 30 (the SRAI marker) must not leak in
  assign imm_shamt = {{(DATA_WIDTH-5){1'b0}}, INSTRUCTION_IN[24:20]};

  // Register-register / register-immediate arithmetic shared by OP and OP-IMM
  // when funct7 carries no extra meaning.
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    logic [4:0] code;
    code = ALU_NOP;
    case (f3)
      3'd0:    code = ALU_ADD;
      3'd1:    code = ALU_SLL;
      3'd2:    code = ALU_SLT;
      3'd3:    code = ALU_SLTU;
      3'd4:    code = ALU_XOR;
      3'd5:    code = ALU_SRL;
      3'd6:    code = ALU_OR;
      3'd7:    code = ALU_AND;
      default: code = ALU_NOP;
    endcase
    return code;
  endfunction

  logic illegal;

  always_comb begin
    dec       = '0;
    illegal   = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = PC_IN;

    case (opcode)
      OPC_OP: begin
        dec.in1_sel   = IN1_RS1;
        dec.in2_sel   = IN2_RS2;
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.rd        = rd_f;
        dec.reg_write = 1'b1;
        if (funct7 == 7'h00) begin
          dec.alu = base_alu(funct3);
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          dec.alu = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          dec.alu = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        dec.in1_sel   = IN1_RS1;
        dec.in2_sel   = IN2_IMM;
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        case (funct3)
          3'd1: begin
            dec.imm = imm_shamt;
            if (funct7 == 7'h00) dec.alu = ALU_SLLI;
            else                 illegal = 1'b1;
          end
          3'd5: begin
            dec.imm = imm_shamt;
            if (funct7 == 7'h00)      dec.alu = ALU_SRLI;
            else if (funct7 == 7'h20) dec.alu = ALU_SRAI;
            else                      illegal = 1'b1;
          end
          default: dec.alu = base_alu(funct3);
        endcase
      end

      OPC_LUI: begin
        dec.alu       = ALU_ADD;
        dec.in1_sel   = IN1_ZERO;
        dec.in2_sel   = IN2_IMM;
        dec.rd        = rd_f;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end

      OPC_AUIPC: begin
        dec.alu       = ALU_ADD;
        dec.in1_sel   = IN1_PC;
        dec.in2_sel   = IN2_IMM;
        dec.rd        = rd_f;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end

      OPC_JAL: begin
        dec.alu       = ALU_JAL;
        dec.in1_sel   = IN1_PC;
        dec.in2_sel   = IN2_IMM;
        dec.rd        = rd_f;
        dec.imm       = imm_j;
        dec.reg_write = 1'b1;
      end

      OPC_JALR: begin
        // Execute forms the link value from PC; rs1 is read for the target.
        dec.alu       = ALU_JALR;
        dec.in1_sel   = IN1_PC;
        dec.in2_sel   = IN2_IMM;
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end

      OPC_BRANCH: begin
        dec.in1_sel = IN1_RS1;
        dec.in2_sel = IN2_RS2;
        dec.rs1     = rs1_f;
        dec.rs2     = rs2_f;
        dec.imm     = imm_b;
        case (funct3)
          3'd0:    dec.alu = ALU_BEQ;
          3'd1:    dec.alu = ALU_BNE;
          3'd4:    dec.alu = ALU_BLT;
          3'd5:    dec.alu = ALU_BGE;
          3'd6:    dec.alu = ALU_BLTU;
          3'd7:    dec.alu = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        dec.alu        = ALU_ADD;
        dec.in1_sel    = IN1_RS1;
        dec.in2_sel    = IN2_IMM;
        dec.rs1        = rs1_f;
        dec.rd         = rd_f;
        dec.imm        = imm_i;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_funct3 = funct3;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
      end

      OPC_STORE: begin
        dec.alu        = ALU_ADD;
        dec.in1_sel    = IN1_RS1;
        dec.in2_sel    = IN2_IMM;
        dec.rs1        = rs1_f;
        dec.rs2        = rs2_f;
        dec.imm        = imm_s;
        dec.mem_write  = 1'b1;
        dec.mem_funct3 = funct3;
        if (funct3 > 3'd2) illegal = 1'b1;
      end

      OPC_FENCE, OPC_SYSTEM: begin
        // Architecturally legal but nothing for this pipeline to do.
        dec.alu = ALU_NOP;
      end

      default: illegal = 1'b1;
    endcase

    // An illegal word travels as a valid bubble so the trap logic sees its PC.
    if (illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec.pc      = PC_IN;
    end

    // x0 is hardwired; writes to it are dropped here rather than in writeback.
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;

    if (!VALID_IN) dec = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_q <= '0;
    end else if (FLUSH) begin
      stage_q <= '0;
    end else if (!STALL) begin
      stage_q <= dec;
    end
  end

  assign VALID_OUT           = stage_q.valid;
  assign ILLEGAL_INSTRUCTION = stage_q.illegal;
  assign ALU_INSTRUCTION     = stage_q.alu;
  assign ALU_IN1_SEL         = stage_q.in1_sel;
  assign ALU_IN2_SEL         = stage_q.in2_sel;
  assign RS1_ADDR            = stage_q.rs1;
  assign RS2_ADDR            = stage_q.rs2;
  assign RD_ADDR             = stage_q.rd;
  assign IMMEDIATE           = stage_q.imm;
  assign REG_WRITE           = stage_q.reg_write;
  assign MEM_READ            = stage_q.mem_read;
  assign MEM_WRITE           = stage_q.mem_write;
  assign MEM_FUNCT3          = stage_q.mem_funct3;
  assign PC_OUT              = stage_q.pc;

endmodule
